// File: rtl/btb_lru.sv
// Fully associative branch target buffer with true-LRU replacement and 2-bit direction counters.
// Lookup is combinational over registered state; training happens on the clocked update port.
module btb_lru #(
  parameter int W_PC  = 8,
  parameter int W_BTA = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     lookup_en,
  input  logic [W_PC-1:0]          lookup_pc,
  output logic                     lookup_hit,
  output logic [W_BTA-1:0]         lookup_bta,
  output logic                     predict_taken,
  input  logic                     upd_valid,
  input  logic [W_PC-1:0]          upd_pc,
  input  logic                     upd_taken,
  input  logic [W_BTA-1:0]         upd_target,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int R = $clog2(DEPTH);
  typedef logic [R-1:0] rank_t;

  logic             valid_q [DEPTH];
  logic             valid_d [DEPTH];
  logic [W_PC-1:0]  tag_q   [DEPTH];
  logic [W_PC-1:0]  tag_d   [DEPTH];
  logic [W_BTA-1:0] bta_q   [DEPTH];
  logic [W_BTA-1:0] bta_d   [DEPTH];
  logic [1:0]       ctr_q   [DEPTH];
  logic [1:0]       ctr_d   [DEPTH];
  rank_t            rank_q  [DEPTH];
  rank_t            rank_mid[DEPTH];
  rank_t            rank_d  [DEPTH];
  logic [R:0]       occ_q, occ_d;

  logic [DEPTH-1:0] lk_match, up_match, free_sel, lru_sel, vic_sel, upd_touch;
  logic [W_BTA-1:0] lk_bta;
  logic             lk_ctr1, up_hit, free_found;
  rank_t            lk_rank, e_rank;

  // Lookup: tags are unique, so OR-reducing the matching entries selects the single hit.
  always_comb begin
    lk_match = '0;
    lk_bta   = '0;
    lk_ctr1  = 1'b0;
    lk_rank  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && tag_q[i] == lookup_pc) begin
        lk_match[i] = 1'b1;
        lk_bta      = lk_bta | bta_q[i];
        lk_ctr1     = lk_ctr1 | ctr_q[i][1];
        lk_rank     = lk_rank | rank_q[i];
      end
    end
  end

  assign lookup_hit    = |lk_match;
  assign lookup_bta    = lk_bta;
  assign predict_taken = lk_ctr1;
  assign occupancy     = occ_q;

  always_comb begin
    up_match   = '0;
    free_sel   = '0;
    lru_sel    = '0;
    free_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      up_match[i] = valid_q[i] && tag_q[i] == upd_pc;
      lru_sel[i]  = rank_q[i] == rank_t'(DEPTH - 1);
      if (!valid_q[i] && !free_found) begin
        free_sel[i] = 1'b1;
        free_found  = 1'b1;
      end
    end
    up_hit    = |up_match;
    vic_sel   = free_found ? free_sel : lru_sel;
    upd_touch = (upd_valid && upd_taken) ? (up_hit ? up_match : vic_sel) : '0;
  end

  // Two chained touches: the fetch lookup first, then the update, so the update ends at MRU.
  always_comb begin
    e_rank = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rank_mid[i] = rank_q[i];
      if (lookup_en && lk_match[i])
        rank_mid[i] = '0;
      else if (lookup_en && lookup_hit && rank_q[i] < lk_rank)
        rank_mid[i] = rank_q[i] + rank_t'(1);
    end
    for (int i = 0; i < DEPTH; i++)
      if (upd_touch[i]) e_rank = e_rank | rank_mid[i];
    for (int i = 0; i < DEPTH; i++) begin
      rank_d[i] = rank_mid[i];
      if (upd_touch[i])
        rank_d[i] = '0;
      else if (|upd_touch && rank_mid[i] < e_rank)
        rank_d[i] = rank_mid[i] + rank_t'(1);
    end
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i];
      tag_d[i]   = tag_q[i];
      bta_d[i]   = bta_q[i];
      ctr_d[i]   = ctr_q[i];
      if (upd_valid && up_match[i]) begin
        if (upd_taken) begin
          bta_d[i] = upd_target;
          ctr_d[i] = (ctr_q[i] == 2'b11) ? 2'b11 : ctr_q[i] + 2'b01;
        end else begin
          ctr_d[i] = (ctr_q[i] == 2'b00) ? 2'b00 : ctr_q[i] - 2'b01;
        end
      end else if (upd_valid && upd_taken && !up_hit && vic_sel[i]) begin
        valid_d[i] = 1'b1;
        tag_d[i]   = upd_pc;
        bta_d[i]   = upd_target;
        ctr_d[i]   = 2'b10;
      end
      occ_d = occ_d + {{R{1'b0}}, valid_d[i]};
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q[gi] <= 1'b0;
        tag_q[gi]   <= '0;
        bta_q[gi]   <= '0;
        ctr_q[gi]   <= 2'b00;
        rank_q[gi]  <= rank_t'(gi);
      end else begin
        valid_q[gi] <= valid_d[gi];
        tag_q[gi]   <= tag_d[gi];
        bta_q[gi]   <= bta_d[gi];
        ctr_q[gi]   <= ctr_d[gi];
        rank_q[gi]  <= rank_d[gi];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) occ_q <= '0;
    else       occ_q <= occ_d;
  end
endmodule

// File: tb/tb_btb_lru.sv
// Self-checking bench for btb_lru: directed scenarios plus random traffic compared against
// a recency-list reference model of the buffer.
module tb_btb_lru;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, lookup_en, upd_valid, upd_taken;
  logic [7:0]  lookup_pc, upd_pc;
  logic [31:0] upd_target, lookup_bta;
  logic        lookup_hit, predict_taken;
  logic [2:0]  occupancy;

  always #5 clk = ~clk;

  btb_lru #(.W_PC(8), .W_BTA(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .lookup_en(lookup_en), .lookup_pc(lookup_pc),
    .lookup_hit(lookup_hit), .lookup_bta(lookup_bta), .predict_taken(predict_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .occupancy(occupancy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit armed    = 1'b0;
  logic last_hit;

  // Reference model: entry contents plus a recency list of entry indices, MRU first.
  bit          m_valid[DEPTH];
  logic [7:0]  m_tag[DEPTH];
  logic [31:0] m_bta[DEPTH];
  int          m_ctr[DEPTH];
  int          order[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_find(input logic [7:0] pc);
    for (int i = 0; i < DEPTH; i++)
      if (m_valid[i] && m_tag[i] == pc) return i;
    return -1;
  endfunction

  function automatic int m_occ();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (m_valid[i]) n++;
    return n;
  endfunction

  function automatic int m_victim();
    for (int i = 0; i < DEPTH; i++) if (!m_valid[i]) return i;
    return order[order.size()-1];
  endfunction

  task automatic m_touch(input int e);
    for (int k = 0; k < order.size(); k++)
      if (order[k] == e) begin
        order.delete(k);
        break;
      end
    order.push_front(e);
  endtask

  task automatic m_reset();
    order.delete();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_bta[i]   = '0;
      m_ctr[i]   = 0;
      order.push_back(i);
    end
  endtask

  task automatic m_apply(input bit rst, input bit le, input logic [7:0] lpc, input bit uv,
                         input logic [7:0] upc, input bit ut, input logic [31:0] utg);
    int l, u, v;
    if (rst) begin
      m_reset();
      return;
    end
    l = m_find(lpc);
    u = m_find(upc);
    v = m_victim();
    if (le && l >= 0) m_touch(l);
    if (uv) begin
      if (u >= 0) begin
        if (ut) begin
          m_bta[u] = utg;
          if (m_ctr[u] < 3) m_ctr[u]++;
          m_touch(u);
        end else if (m_ctr[u] > 0) begin
          m_ctr[u]--;
        end
      end else if (ut) begin
        m_valid[v] = 1'b1;
        m_tag[v]   = upc;
        m_bta[v]   = utg;
        m_ctr[v]   = 2;
        m_touch(v);
      end
    end
  endtask

  // One clock: drive at the falling edge, compare lookup outputs against the model, then clock.
  task automatic step(input bit rst, input bit le, input logic [7:0] lpc, input bit uv,
                      input logic [7:0] upc, input bit ut, input logic [31:0] utg);
    int f;
    reset = rst; lookup_en = le; lookup_pc = lpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg;
    #1;
    last_hit = lookup_hit;
    if (armed) begin
      f = m_find(lpc);
      check("hit", 64'(lookup_hit), 64'(f >= 0));
      check("bta", 64'(lookup_bta), (f >= 0) ? 64'(m_bta[f]) : 64'd0);
      check("pred", 64'(predict_taken), 64'(f >= 0 && m_ctr[f] >= 2));
      check("occ", 64'(occupancy), 64'(m_occ()));
    end
    @(posedge clk);
    m_apply(rst, le, lpc, uv, upc, ut, utg);
    armed = 1'b1;
    @(negedge clk);
  endtask

  task automatic alloc(input logic [7:0] pc, input logic [31:0] tgt);
    step(1'b0, 1'b0, 8'h00, 1'b1, pc, 1'b1, tgt);
  endtask

  task automatic train(input logic [7:0] pc, input bit tk, input logic [31:0] tgt);
    step(1'b0, 1'b0, 8'h00, 1'b1, pc, tk, tgt);
  endtask

  // Explicit expectations from the scenario description; no state change on this edge.
  task automatic peek(input logic [7:0] pc, input bit eh, input logic [31:0] eb, input bit ep);
    reset = 1'b0; lookup_en = 1'b0; upd_valid = 1'b0; lookup_pc = pc;
    #1;
    check("peek_hit", 64'(lookup_hit), 64'(eh));
    check("peek_bta", 64'(lookup_bta), 64'(eb));
    check("peek_pred", 64'(predict_taken), 64'(ep));
    @(negedge clk);
  endtask

  initial begin
    m_reset();
    reset = 1'b1; lookup_en = 1'b0; lookup_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    @(negedge clk);

    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 32'h0);
    peek(8'h08, 1'b0, 32'h0, 1'b0);
    check("occ_reset", 64'(occupancy), 64'd0);

    step(1'b0, 1'b1, 8'h08, 1'b1, 8'h08, 1'b1, 32'h11);
    check("same_cycle_hit", 64'(last_hit), 64'd0);
    peek(8'h08, 1'b1, 32'h11, 1'b1);
    check("occ_one", 64'(occupancy), 64'd1);

    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 32'h0);
    for (int p = 1; p <= 4; p++) alloc(8'(p), 32'(p + 'h100));
    step(1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 32'h0);
    alloc(8'h05, 32'h105);
    peek(8'h02, 1'b0, 32'h0, 1'b0);
    peek(8'h01, 1'b1, 32'h101, 1'b1);
    peek(8'h03, 1'b1, 32'h103, 1'b1);
    peek(8'h04, 1'b1, 32'h104, 1'b1);
    peek(8'h05, 1'b1, 32'h105, 1'b1);
    check("occ_full", 64'(occupancy), 64'd4);

    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 32'h0);
    alloc(8'h20, 32'h20);
    train(8'h20, 1'b0, 32'h0);
    peek(8'h20, 1'b1, 32'h20, 1'b0);
    train(8'h20, 1'b0, 32'h0);
    train(8'h20, 1'b0, 32'h0);
    peek(8'h20, 1'b1, 32'h20, 1'b0);
    train(8'h20, 1'b1, 32'h20);
    peek(8'h20, 1'b1, 32'h20, 1'b0);
    train(8'h20, 1'b1, 32'h20);
    train(8'h20, 1'b1, 32'h20);
    peek(8'h20, 1'b1, 32'h20, 1'b1);
    train(8'h20, 1'b0, 32'h0);
    peek(8'h20, 1'b1, 32'h20, 1'b1);
    train(8'h20, 1'b1, 32'h40);
    peek(8'h20, 1'b1, 32'h40, 1'b1);
    check("occ_retarget", 64'(occupancy), 64'd1);

    train(8'h30, 1'b0, 32'h0);
    check("occ_nt_miss", 64'(occupancy), 64'd1);
    peek(8'h30, 1'b0, 32'h0, 1'b0);

    alloc(8'h61, 32'h61);
    alloc(8'h62, 32'h62);
    alloc(8'h63, 32'h63);
    check("occ_before_rst", 64'(occupancy), 64'd4);
    step(1'b1, 1'b0, 8'h00, 1'b1, 8'h50, 1'b1, 32'h50);
    peek(8'h50, 1'b0, 32'h0, 1'b0);
    peek(8'h20, 1'b0, 32'h0, 1'b0);
    check("occ_after_rst", 64'(occupancy), 64'd0);
    for (int p = 0; p < 4; p++) alloc(8'(8'hA1 + p), 32'(p + 'hA00));
    alloc(8'hA5, 32'hA05);
    peek(8'hA1, 1'b0, 32'h0, 1'b0);
    peek(8'hA2, 1'b1, 32'hA01, 1'b1);
    peek(8'hA5, 1'b1, 32'hA05, 1'b1);

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) == 0), 1'($urandom), 8'($urandom_range(0, 11)),
           1'($urandom), 8'($urandom_range(0, 11)), 1'($urandom), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
